// File: rtl/warp_fetcher_if.sv
// Fetch-request, program-memory read and instruction-return signals of the warp fetcher.
// master: scheduler/memory side that drives requests and read data; slave: the fetcher itself.
interface warp_fetcher_if #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 16,
  parameter int WARP_ID_BITS = 1
);
  logic                    fetch_req;
  logic [WARP_ID_BITS-1:0] fetch_warp_id;
  logic [ADDR_BITS-1:0]    fetch_pc;
  logic                    icache_flush;
  logic                    mem_read_valid;
  logic [ADDR_BITS-1:0]    mem_read_address;
  logic                    mem_read_ready;
  logic [DATA_BITS-1:0]    mem_read_data;
  logic                    instruction_ready;
  logic [DATA_BITS-1:0]    instruction;
  logic [WARP_ID_BITS-1:0] instruction_warp_id;
  logic [1:0]              fetcher_state;
  logic [15:0]             fetch_miss_count;

  modport master (
    output fetch_req, fetch_warp_id, fetch_pc, icache_flush, mem_read_ready, mem_read_data,
    input  mem_read_valid, mem_read_address, instruction_ready, instruction,
           instruction_warp_id, fetcher_state, fetch_miss_count
  );

  modport slave (
    input  fetch_req, fetch_warp_id, fetch_pc, icache_flush, mem_read_ready, mem_read_data,
    output mem_read_valid, mem_read_address, instruction_ready, instruction,
           instruction_warp_id, fetcher_state, fetch_miss_count
  );
endinterface

// File: rtl/warp_fetcher.sv
// Instruction fetch: returns the word at a warp's PC in 2 cycles on a cache hit or 1 cycle after mem_read_ready;
// mem_read_valid/address hold until ready. Optional shared direct-mapped icache under `WARP_FETCHER_ICACHE_EN.
module warp_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int MAX_WARPS_PER_CORE    = 2,
  parameter int WARP_ID_BITS          = $clog2(MAX_WARPS_PER_CORE),
  parameter int ICACHE_LINES          = 4
) (
  input  logic           clk,
  input  logic           reset,
  warp_fetcher_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_LOOKUP   = 2'b01,
    ST_FETCHING = 2'b10,
    ST_DONE     = 2'b11
  } state_t;

  state_t                           state_q, state_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] pc_q, pc_d;
  logic [WARP_ID_BITS-1:0]          wid_q, wid_d;
  logic                             mem_vld_q, mem_vld_d;
  logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q, instr_d;
  logic                             instr_rdy_q, instr_rdy_d;
  logic [15:0]                      miss_q, miss_d;

`ifdef WARP_FETCHER_ICACHE_EN
  localparam int IDX_BITS = $clog2(ICACHE_LINES);
  localparam int TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX_BITS;

  logic [ICACHE_LINES-1:0]          valid_q;
  logic [TAG_BITS-1:0]              tag_q  [ICACHE_LINES];
  logic [PROGRAM_MEM_DATA_BITS-1:0] data_q [ICACHE_LINES];
  logic [IDX_BITS-1:0]              idx;
  logic [TAG_BITS-1:0]              tag;
  logic                             hit;
  logic                             fill;

  assign idx  = pc_q[IDX_BITS-1:0];
  assign tag  = pc_q[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
  assign hit  = valid_q[idx] && (tag_q[idx] == tag);
  assign fill = (state_q == ST_FETCHING) && bus.mem_read_ready;

  // Flush has priority over a same-cycle fill; the word is still delivered.
  always_ff @(posedge clk) begin
    if (reset || bus.icache_flush) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= bus.mem_read_data;
    end
  end
`else
  logic unused_flush;
  assign unused_flush = bus.icache_flush;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    wid_d       = wid_q;
    mem_vld_d   = mem_vld_q;
    instr_d     = instr_q;
    instr_rdy_d = 1'b0;
    miss_d      = miss_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.fetch_req) begin
          pc_d  = bus.fetch_pc;
          wid_d = bus.fetch_warp_id;
`ifdef WARP_FETCHER_ICACHE_EN
          state_d = ST_LOOKUP;
`else
          mem_vld_d = 1'b1;
          state_d   = ST_FETCHING;
`endif
        end
      end
      ST_LOOKUP: begin
`ifdef WARP_FETCHER_ICACHE_EN
        if (hit) begin
          instr_d     = data_q[idx];
          instr_rdy_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          mem_vld_d = 1'b1;
          state_d   = ST_FETCHING;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_FETCHING: begin
        if (bus.mem_read_ready) begin
          instr_d     = bus.mem_read_data;
          instr_rdy_d = 1'b1;
          mem_vld_d   = 1'b0;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!bus.fetch_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Count each rising edge of the memory request, saturating.
    if (mem_vld_d && !mem_vld_q && (miss_q != 16'hFFFF)) begin
      miss_d = miss_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      wid_q       <= '0;
      mem_vld_q   <= 1'b0;
      instr_q     <= '0;
      instr_rdy_q <= 1'b0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      wid_q       <= wid_d;
      mem_vld_q   <= mem_vld_d;
      instr_q     <= instr_d;
      instr_rdy_q <= instr_rdy_d;
      miss_q      <= miss_d;
    end
  end

  // The latched PC doubles as the read address; it only changes in IDLE.
  assign bus.mem_read_valid      = mem_vld_q;
  assign bus.mem_read_address    = pc_q;
  assign bus.instruction_ready   = instr_rdy_q;
  assign bus.instruction         = instr_q;
  assign bus.instruction_warp_id = wid_q;
  assign bus.fetcher_state       = state_q;
  assign bus.fetch_miss_count    = miss_q;

endmodule

// File: tb/tb_warp_fetcher.sv
// Directed self-checking bench for warp_fetcher; cache scenarios run when WARP_FETCHER_ICACHE_EN is defined.
module tb_warp_fetcher;

`ifdef WARP_FETCHER_ICACHE_EN
  localparam int REQ_TO_VLD = 2;
`else
  localparam int REQ_TO_VLD = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  warp_fetcher_if #(.ADDR_BITS(8), .DATA_BITS(16), .WARP_ID_BITS(1)) bus ();

  warp_fetcher #(
    .PROGRAM_MEM_ADDR_BITS(8),
    .PROGRAM_MEM_DATA_BITS(16),
    .MAX_WARPS_PER_CORE(2),
    .WARP_ID_BITS(1),
    .ICACHE_LINES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Stimulus driver only: issues one fetch, answers it from memory if asked, then releases fetch_req.
  task automatic run_fetch(input logic [7:0] pc, input logic wid, input logic [15:0] data,
                           input int waits, input logic flush,
                           output logic saw_vld, output int lat, output logic [7:0] addr,
                           output logic [15:0] instr, output int pulses);
    saw_vld = 1'b0; lat = 0; addr = '0; instr = '0; pulses = 0;
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_pc = pc; bus.fetch_warp_id = wid; bus.mem_read_ready = 1'b0;
    while (lat < 20 && !bus.mem_read_valid && !bus.instruction_ready) begin
      @(negedge clk);
      lat++;
    end
    if (bus.mem_read_valid) begin
      saw_vld = 1'b1;
      addr    = bus.mem_read_address;
      repeat (waits) @(negedge clk);
      bus.mem_read_ready = 1'b1; bus.mem_read_data = data; bus.icache_flush = flush;
      @(negedge clk);
      bus.mem_read_ready = 1'b0; bus.icache_flush = 1'b0;
    end
    instr = bus.instruction;
    repeat (4) begin
      if (bus.instruction_ready) pulses++;
      @(negedge clk);
    end
    bus.fetch_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.fetch_req = 1'b0; bus.fetch_warp_id = '0; bus.fetch_pc = '0; bus.icache_flush = 1'b0;
    bus.mem_read_ready = 1'b0; bus.mem_read_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.fetcher_state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0h exp=0", bus.fetcher_state); end
    checks++; if (bus.mem_read_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", bus.mem_read_valid); end
    checks++; if (bus.mem_read_address !== 8'h00) begin failures++; $display("FAIL rst_addr got=%0h exp=0", bus.mem_read_address); end
    checks++; if (bus.instruction !== 16'h0000) begin failures++; $display("FAIL rst_instr got=%0h exp=0", bus.instruction); end
    checks++; if (bus.instruction_ready !== 1'b0) begin failures++; $display("FAIL rst_rdy got=%0h exp=0", bus.instruction_ready); end
    checks++; if (bus.instruction_warp_id !== 1'b0) begin failures++; $display("FAIL rst_wid got=%0h exp=0", bus.instruction_warp_id); end
    checks++; if (bus.fetch_miss_count !== 16'd0) begin failures++; $display("FAIL rst_miss got=%0h exp=0", bus.fetch_miss_count); end
  endtask

  task automatic test_fetch_miss();
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_pc = 8'h05; bus.fetch_warp_id = 1'b1; bus.mem_read_ready = 1'b0;
    repeat (REQ_TO_VLD) @(negedge clk);
    checks++; if (bus.mem_read_valid !== 1'b1) begin failures++; $display("FAIL miss_valid got=%0h exp=1", bus.mem_read_valid); end
    checks++; if (bus.mem_read_address !== 8'h05) begin failures++; $display("FAIL miss_addr got=%0h exp=05", bus.mem_read_address); end
    checks++; if (bus.fetcher_state !== 2'd2) begin failures++; $display("FAIL miss_state got=%0h exp=2", bus.fetcher_state); end
    checks++; if (bus.fetch_miss_count !== 16'd1) begin failures++; $display("FAIL miss_count got=%0h exp=1", bus.fetch_miss_count); end
    @(negedge clk);
    checks++; if (bus.mem_read_valid !== 1'b1 || bus.instruction_ready !== 1'b0) begin failures++; $display("FAIL miss_wait got=%0h%0h exp=10", bus.mem_read_valid, bus.instruction_ready); end
    bus.mem_read_ready = 1'b1; bus.mem_read_data = 16'h3A21;
    @(negedge clk);
    bus.mem_read_ready = 1'b0; bus.mem_read_data = 16'h0000;
    checks++; if (bus.instruction_ready !== 1'b1) begin failures++; $display("FAIL miss_rdy got=%0h exp=1", bus.instruction_ready); end
    checks++; if (bus.instruction !== 16'h3A21) begin failures++; $display("FAIL miss_instr got=%0h exp=3a21", bus.instruction); end
    checks++; if (bus.instruction_warp_id !== 1'b1) begin failures++; $display("FAIL miss_wid got=%0h exp=1", bus.instruction_warp_id); end
    checks++; if (bus.mem_read_valid !== 1'b0) begin failures++; $display("FAIL miss_vld_drop got=%0h exp=0", bus.mem_read_valid); end
    checks++; if (bus.fetcher_state !== 2'd3) begin failures++; $display("FAIL miss_done got=%0h exp=3", bus.fetcher_state); end
    @(negedge clk);
    checks++; if (bus.instruction_ready !== 1'b0 || bus.instruction !== 16'h3A21) begin failures++; $display("FAIL miss_pulse_hold got=%0h/%0h exp=0/3a21", bus.instruction_ready, bus.instruction); end
    bus.fetch_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.fetcher_state !== 2'd0) begin failures++; $display("FAIL miss_idle got=%0h exp=0", bus.fetcher_state); end
  endtask

  task automatic test_hold_req();
    int pulses;
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_pc = 8'h10; bus.fetch_warp_id = 1'b0;
    bus.mem_read_ready = 1'b1; bus.mem_read_data = 16'h1234;
    repeat (REQ_TO_VLD) @(negedge clk);
    checks++; if (bus.mem_read_valid !== 1'b1) begin failures++; $display("FAIL hold_valid got=%0h exp=1", bus.mem_read_valid); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.mem_read_ready = 1'b0;
      if (bus.instruction_ready) pulses++;
    end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL hold_pulses got=%0d exp=1", pulses); end
    checks++; if (bus.fetcher_state !== 2'd3) begin failures++; $display("FAIL hold_done got=%0h exp=3", bus.fetcher_state); end
    checks++; if (bus.instruction !== 16'h1234) begin failures++; $display("FAIL hold_instr got=%0h exp=1234", bus.instruction); end
    bus.fetch_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.fetcher_state !== 2'd0) begin failures++; $display("FAIL hold_idle got=%0h exp=0", bus.fetcher_state); end
    @(negedge clk);
    checks++; if (bus.fetcher_state !== 2'd0 || bus.mem_read_valid !== 1'b0) begin failures++; $display("FAIL hold_stay_idle got=%0h/%0h exp=0/0", bus.fetcher_state, bus.mem_read_valid); end
    checks++; if (bus.fetch_miss_count !== 16'd2) begin failures++; $display("FAIL hold_miss got=%0h exp=2", bus.fetch_miss_count); end
  endtask

  task automatic test_back_to_back();
    logic sv; int lat; logic [7:0] addr; logic [15:0] instr; int pulses;
    run_fetch(8'h33, 1'b1, 16'hBEEF, 1, 1'b0, sv, lat, addr, instr, pulses);
    checks++; if (instr !== 16'hBEEF || pulses !== 1) begin failures++; $display("FAIL b2b_first got=%0h/%0d exp=beef/1", instr, pulses); end
    run_fetch(8'h34, 1'b0, 16'hCAFE, 0, 1'b0, sv, lat, addr, instr, pulses);
    checks++; if (lat !== REQ_TO_VLD) begin failures++; $display("FAIL b2b_lat got=%0d exp=%0d", lat, REQ_TO_VLD); end
    checks++; if (addr !== 8'h34) begin failures++; $display("FAIL b2b_addr got=%0h exp=34", addr); end
    checks++; if (instr !== 16'hCAFE || pulses !== 1) begin failures++; $display("FAIL b2b_second got=%0h/%0d exp=cafe/1", instr, pulses); end
    checks++; if (bus.instruction_warp_id !== 1'b0) begin failures++; $display("FAIL b2b_wid got=%0h exp=0", bus.instruction_warp_id); end
    checks++; if (bus.fetch_miss_count !== 16'd4) begin failures++; $display("FAIL b2b_miss got=%0h exp=4", bus.fetch_miss_count); end
  endtask

  task automatic test_reset_midfetch();
    int late;
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_pc = 8'h21; bus.fetch_warp_id = 1'b1; bus.mem_read_ready = 1'b0;
    repeat (REQ_TO_VLD) @(negedge clk);
    checks++; if (bus.mem_read_valid !== 1'b1) begin failures++; $display("FAIL rmf_valid got=%0h exp=1", bus.mem_read_valid); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; bus.fetch_req = 1'b0;
    checks++; if (bus.fetcher_state !== 2'd0) begin failures++; $display("FAIL rmf_state got=%0h exp=0", bus.fetcher_state); end
    checks++; if (bus.mem_read_valid !== 1'b0) begin failures++; $display("FAIL rmf_vld got=%0h exp=0", bus.mem_read_valid); end
    checks++; if (bus.fetch_miss_count !== 16'd0) begin failures++; $display("FAIL rmf_miss got=%0h exp=0", bus.fetch_miss_count); end
    bus.mem_read_ready = 1'b1; bus.mem_read_data = 16'hDEAD;
    late = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.instruction_ready) late++;
    end
    bus.mem_read_ready = 1'b0;
    checks++; if (late !== 0) begin failures++; $display("FAIL rmf_late_rdy got=%0d exp=0", late); end
    checks++; if (bus.instruction !== 16'h0000 || bus.fetcher_state !== 2'd0) begin failures++; $display("FAIL rmf_after got=%0h/%0h exp=0/0", bus.instruction, bus.fetcher_state); end
  endtask

`ifdef WARP_FETCHER_ICACHE_EN
  task automatic test_cache_hit();
    logic sv; int lat; logic [7:0] addr; logic [15:0] instr; int pulses;
    run_fetch(8'h04, 1'b0, 16'h7001, 1, 1'b0, sv, lat, addr, instr, pulses);
    checks++; if (sv !== 1'b1 || instr !== 16'h7001) begin failures++; $display("FAIL hit_fill got=%0h/%0h exp=1/7001", sv, instr); end
    run_fetch(8'h04, 1'b1, 16'h0BAD, 0, 1'b0, sv, lat, addr, instr, pulses);
    checks++; if (sv !== 1'b0) begin failures++; $display("FAIL hit_no_mem got=%0h exp=0", sv); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL hit_lat got=%0d exp=2", lat); end
    checks++; if (instr !== 16'h7001 || pulses !== 1) begin failures++; $display("FAIL hit_data got=%0h/%0d exp=7001/1", instr, pulses); end
    checks++; if (bus.instruction_warp_id !== 1'b1) begin failures++; $display("FAIL hit_wid got=%0h exp=1", bus.instruction_warp_id); end
    checks++; if (bus.fetch_miss_count !== 16'd1) begin failures++; $display("FAIL hit_miss got=%0h exp=1", bus.fetch_miss_count); end
  endtask

  task automatic test_cache_conflict();
    logic sv; int lat; logic [7:0] addr; logic [15:0] instr; int pulses;
    run_fetch(8'h08, 1'b0, 16'h5008, 0, 1'b0, sv, lat, addr, instr, pulses);
    checks++; if (sv !== 1'b1 || addr !== 8'h08) begin failures++; $display("FAIL conf_08 got=%0h/%0h exp=1/08", sv, addr); end
    run_fetch(8'h04, 1'b0, 16'h7001, 0, 1'b0, sv, lat, addr, instr, pulses);
    checks++; if (sv !== 1'b1 || instr !== 16'h7001) begin failures++; $display("FAIL conf_04 got=%0h/%0h exp=1/7001", sv, instr); end
    checks++; if (bus.fetch_miss_count !== 16'd3) begin failures++; $display("FAIL conf_miss got=%0h exp=3", bus.fetch_miss_count); end
  endtask

  task automatic test_cache_flush();
    logic sv; int lat; logic [7:0] addr; logic [15:0] instr; int pulses;
    run_fetch(8'h02, 1'b0, 16'h2222, 0, 1'b1, sv, lat, addr, instr, pulses);
    checks++; if (instr !== 16'h2222 || pulses !== 1) begin failures++; $display("FAIL flush_deliver got=%0h/%0d exp=2222/1", instr, pulses); end
    run_fetch(8'h02, 1'b0, 16'h2223, 0, 1'b0, sv, lat, addr, instr, pulses);
    checks++; if (sv !== 1'b1 || instr !== 16'h2223) begin failures++; $display("FAIL flush_refetch got=%0h/%0h exp=1/2223", sv, instr); end
    checks++; if (bus.fetch_miss_count !== 16'd5) begin failures++; $display("FAIL flush_miss got=%0h exp=5", bus.fetch_miss_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_miss();
    test_hold_req();
    test_back_to_back();
    test_reset_midfetch();
`ifdef WARP_FETCHER_ICACHE_EN
    test_cache_hit();
    test_cache_conflict();
    test_cache_flush();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/warp_fetcher.md
# warp_fetcher

Instruction fetch stage for one compute core, sitting directly upstream of the warp scheduler. When the scheduler requests the instruction at a warp's PC, this block returns the 16-bit instruction word together with a one-cycle `instruction_ready` pulse. It obtains the word from an optional direct-mapped instruction cache, or otherwise through a valid/ready read handshake to program memory. The cache is shared by all warps because every warp runs the same kernel.

## Interface
- `PROGRAM_MEM_ADDR_BITS`, default 8: PC and program-memory address width.
- `PROGRAM_MEM_DATA_BITS`, default 16: instruction width.
- `MAX_WARPS_PER_CORE`, default 2: number of warps per core.
- `WARP_ID_BITS`, default `$clog2(MAX_WARPS_PER_CORE)`: warp id width.
- `ICACHE_LINES`, default 4: cache lines; must be a power of two and ≥2. Used only with the cache feature.

Ports:
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `fetch_req` input 1: integration drives this as scheduler state==FETCHING && !warp_done[current_warp_id].
- `fetch_warp_id` input WARP_ID_BITS: warp being fetched.
- `fetch_pc` input ADDR_BITS: PC of that warp.
- `icache_flush` input 1: invalidates all cache lines; pulsed at kernel launch.
- `mem_read_valid` output 1: program-memory read request.
- `mem_read_address` output ADDR_BITS: read address.
- `mem_read_ready` input 1: read data valid this cycle.
- `mem_read_data` input DATA_BITS: instruction from memory.
- `instruction_ready` output 1: one-cycle pulse; `instruction` is valid.
- `instruction` output DATA_BITS: fetched word; holds until the next fetch completes.
- `instruction_warp_id` output WARP_ID_BITS: warp id latched with the request.
- `fetcher_state` output 2: 00 IDLE, 01 LOOKUP, 10 FETCHING, 11 DONE.
- `fetch_miss_count` output 16: number of program-memory reads issued, saturating.

## Operation
- IDLE: when `fetch_req` is sampled high, latch `fetch_pc` and `fetch_warp_id`.
  - With cache: go to LOOKUP.
  - Without cache: assert `mem_read_valid` with `mem_read_address`=PC and go to FETCHING.
- Request inputs are sampled only in IDLE. Changes to them while busy are ignored.
- LOOKUP:
  - Index = PC[log2(ICACHE_LINES)-1:0]; tag = the remaining upper PC bits.
  - Hit (line valid and tag equal): `instruction` is loaded from the line, `instruction_ready` goes high, and the block moves to DONE.
  - Miss: assert `mem_read_valid` with the PC and go to FETCHING.
- FETCHING:
  - `mem_read_valid` and the address stay stable until `mem_read_ready` is sampled high.
  - On that cycle: capture `mem_read_data` into `instruction`, drop `mem_read_valid`, pulse `instruction_ready`, go to DONE, and fill the cache line (set valid, write tag and data).
- DONE:
  - `instruction_ready` is high only on the first DONE cycle.
  - Return to IDLE on the first cycle `fetch_req` is sampled low. A new request is accepted no earlier than the cycle after that.
- `fetch_miss_count` increments on every cycle `mem_read_valid` rises. It saturates at 0xFFFF.
- `icache_flush` clears all valid bits in any state. If a fill and a flush occur in the same cycle, the flush wins: the line stays invalid, but the instruction is still delivered.
- Reset values:
  - State IDLE.
  - `mem_read_valid`, `mem_read_address`, `instruction`, `instruction_ready`, `instruction_warp_id` all 0.
  - `fetch_miss_count` 0; all valid bits cleared.
- Reset mid-fetch: the block returns to IDLE on the next edge and any outstanding memory response is ignored. Memory must tolerate an abandoned request.

## Timing
- Request sampled at edge T.
- Cache hit: LOOKUP at T+1; `instruction_ready` high in cycle T+2.
- Cache miss: `mem_read_valid` high from T+2.
- No cache: `mem_read_valid` high from T+1.
- Memory response: if `mem_read_ready` is sampled at edge M, `instruction_ready` and `instruction` are valid in cycle M+1, and `mem_read_valid` is low in M+1.
- `mem_read_ready` arriving in the same cycle `mem_read_valid` first rises is accepted.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `WARP_FETCHER_ICACHE_EN`:
  - Defined: cache and LOOKUP state are present; `icache_flush` is functional.
  - Undefined: no cache storage; LOOKUP is never entered; `icache_flush` is ignored; every fetch goes to memory.

## Test plan
- No cache: request PC=0x05, warp 1; memory answers 0x3A21 with 2 cycles of wait → `mem_read_address`=0x05; `instruction`=0x3A21 and `instruction_warp_id`=1 with a one-cycle `instruction_ready`; miss count=1.
- Cache: fetch PC=0x04 (miss, data 0x7001), drop `fetch_req`, fetch PC=0x04 again → second fetch gives `instruction_ready` at T+2 with no `mem_read_valid`; miss count stays 1.
- Cache conflict: with 4 lines, fetch 0x04 then 0x08 then 0x04 → three memory reads; miss count=3.
- `icache_flush` on the same cycle that `mem_read_ready` returns for PC=0x02 → instruction delivered; a refetch of 0x02 misses.
- Reset asserted in FETCHING with `mem_read_valid` high → next cycle: IDLE, `mem_read_valid`=0, miss count=0; a late `mem_read_ready` does not produce `instruction_ready`.
- Hold `fetch_req` high for 5 cycles after DONE → `instruction_ready` pulses exactly once; IDLE is reached one cycle after `fetch_req` is low.
